// File: rtl/parallax_scroll_controller.sv
// -----------------------------------------------------------------------------
// parallax_scroll_controller
//
// Scrolls NUM_LAYERS background layers vertically once per video frame. Each
// layer k moves by the latched player speed divided by 2^(FRAC_BITS+k), so
// deeper layers move more slowly. On each frame the layers are updated one per
// cycle, and then update_done pulses.
//
// Optional feature macro: SCROLL_SUBPIXEL_EN
//   defined   : each layer keeps a fractional accumulator, so slow speeds
//               still produce motion over several frames.
//   undefined : the step is the speed shifted right and truncated. No
//               accumulator registers are built.
//
// Ports
//   clk          in   system clock, posedge
//   resetN       in   asynchronous active-low reset
//   frame_start  in   one-cycle pulse at the start of a video frame
//   player_speed in   unsigned speed, sampled with frame_start
//   pause        in   freezes layer y and accumulators
//   new_state    out  per layer {img_id, x, y, width, height}
//                     (index 4 = img_id ... index 0 = height)
//   busy         out  FSM in UPDATE or DONE
//   update_done  out  one-cycle pulse when all layers are updated
//   overrun      out  sticky; frame_start seen while busy
//
// FSM states
//   state  | meaning
//   IDLE   | waiting for frame_start
//   UPDATE | updating layer idx, one layer per cycle
//   DONE   | single cycle, update_done high
// -----------------------------------------------------------------------------
module parallax_scroll_controller #(
  parameter int NUM_LAYERS = 2,
  parameter int COORD_W    = 11,
  parameter int SPEED_W    = 10,
  parameter int FRAC_BITS  = 5,
  parameter int BASE_IMG   = 31
) (
  input  logic                                    clk,
  input  logic                                    resetN,
  input  logic                                    frame_start,
  input  logic [SPEED_W-1:0]                      player_speed,
  input  logic                                    pause,
  output logic [NUM_LAYERS-1:0][4:0][COORD_W-1:0] new_state,
  output logic                                    busy,
  output logic                                    update_done,
  output logic                                    overrun
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_UPDATE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  // The width is wide enough that frac + speed cannot overflow, and wide enough
  // to hold height-1 for the clamp compare.
  localparam int ACC_W = SPEED_W + COORD_W + FRAC_BITS + NUM_LAYERS;

  localparam logic [COORD_W-1:0] INIT_X    = COORD_W'(32);
  localparam logic [COORD_W-1:0] WIDTH     = COORD_W'(512);
  localparam logic [COORD_W-1:0] HEIGHT    = COORD_W'(480);
  localparam logic [COORD_W-1:0] HEIGHT_M1 = COORD_W'(479);

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic               overrun_q, overrun_d;
  logic               update_done_q, update_done_d;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    speed_d       = speed_q;
    overrun_d     = overrun_q;
    update_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          speed_d = player_speed;
          idx_d   = '0;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        if (frame_start) overrun_d = 1'b1;
        if (idx_q == IDX_W'(NUM_LAYERS - 1)) begin
          idx_d         = '0;
          state_d       = ST_DONE;
          // Registered so that update_done is high for the whole DONE cycle.
          update_done_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (frame_start) overrun_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      speed_q       <= '0;
      overrun_q     <= 1'b0;
      update_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      speed_q       <= speed_d;
      overrun_q     <= overrun_d;
      update_done_q <= update_done_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign update_done = update_done_q;
  assign overrun     = overrun_q;

  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
    localparam int S = FRAC_BITS + k;

    logic               upd;
    logic [ACC_W-1:0]   sum;
    logic [ACC_W-1:0]   step_full;
    logic [COORD_W-1:0] delta;
    logic [COORD_W-1:0] y_q, y_d;

    assign upd = (state_q == ST_UPDATE) && (idx_q == IDX_W'(k)) && !pause;

`ifdef SCROLL_SUBPIXEL_EN
    logic [S-1:0] frac_q, frac_d;

    assign sum = ACC_W'(frac_q) + ACC_W'(speed_q);

    always_comb begin
      frac_d = frac_q;
      if (upd) frac_d = sum[S-1:0];
    end

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) frac_q <= '0;
      else         frac_q <= frac_d;
    end
`else
    assign sum = ACC_W'(speed_q);
`endif

    assign step_full = sum >> S;
    // The step is clamped to height-1 so that one wrap never skips a full screen.
    assign delta = (step_full > ACC_W'(HEIGHT_M1)) ? HEIGHT_M1 : step_full[COORD_W-1:0];

    always_comb begin
      y_d = y_q;
      if (upd) begin
        if (y_q < delta) y_d = y_q + HEIGHT - delta;
        else             y_d = y_q - delta;
      end
    end

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) y_q <= '0;
      else         y_q <= y_d;
    end

    assign new_state[k][4] = COORD_W'(BASE_IMG + k);
    assign new_state[k][3] = INIT_X;
    assign new_state[k][2] = y_q;
    assign new_state[k][1] = WIDTH;
    assign new_state[k][0] = HEIGHT;
  end

endmodule
